ob_lm_table_cnt_seq: RTL and testbench



---
 rtl/ob_pkg.sv | 26 ++
 rtl/ob_lm_table_cnt_csa.sv | 62 ++++++
 rtl/ob_lm_table_cnt_seq.sv | 181 ++++++++++++++++++
 tb/tb_ob_lm_table_cnt_seq.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ob_pkg.sv
// Shared types for the ob level-manager blocks: CSA operator selection,
// table-count sequencer FSM states, and the sequencer accumulator width.
package ob_pkg;

  // Reduction operator used by ob_lm_table_cnt_csa
  typedef enum logic [0:0] {
    CSA_3_2 = 1'b0,
    CSA_4_2 = 1'b1
  } ob_csa_op_e;

  // Table-count sequencer control states
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FETCH = 3'd1,
    DRAIN = 3'd2,
    CPA   = 3'd3,
    RSP   = 3'd4
  } ob_lm_table_cnt_seq_state_t;

  // Accumulator width: enough headroom that summing a full table of
  // W-bit entries never wraps inside the carry-save registers.
  function automatic int ob_lm_table_cnt_acc_w(input int w, input int entries);
    return w + $clog2(entries) + 1;
  endfunction

endpackage

// File: rtl/ob_lm_table_cnt_csa.sv
// Carry-save reduction of N W-bit operands down to a sum/carry pair.
// OP selects 3:2 compressor folding or 4:2 compressor folding; both give
// sum_o + carry_o == sum of all inputs (mod 2^W).
module ob_lm_table_cnt_csa
  import ob_pkg::*;
#(
  parameter int         W  = 8,
  parameter int         N  = 3,
  parameter ob_csa_op_e OP = CSA_3_2
) (
  input  logic [N*W-1:0] in_i,
  output logic [W-1:0]   sum_o,
  output logic [W-1:0]   carry_o
);

  logic [W-1:0]   s_c;
  logic [W-1:0]   c_c;
  logic [2*W-1:0] t0_c;
  logic [2*W-1:0] t1_c;

  // One full-adder row: {carry, sum}
  function automatic logic [2*W-1:0] csa3(input logic [W-1:0] a,
                                          input logic [W-1:0] b,
                                          input logic [W-1:0] d);
    logic [W-1:0] maj;
    maj = (a & b) | (a & d) | (b & d);
    return {maj << 1, a ^ b ^ d};
  endfunction

  // Fold the remaining operands into the running sum/carry pair
  always_comb begin
    s_c  = in_i[W-1:0];
    c_c  = in_i[2*W-1:W];
    t0_c = '0;
    t1_c = '0;
    if (OP == CSA_4_2) begin
      for (int i = 2; i < N; i += 2) begin
        if (i + 1 < N) begin
          // 4:2 compressor: two new operands plus the running pair
          t0_c = csa3(in_i[i*W +: W], in_i[(i+1)*W +: W], s_c);
          t1_c = csa3(t0_c[W-1:0], t0_c[2*W-1:W], c_c);
          s_c  = t1_c[W-1:0];
          c_c  = t1_c[2*W-1:W];
        end else begin
          t0_c = csa3(s_c, c_c, in_i[i*W +: W]);
          s_c  = t0_c[W-1:0];
          c_c  = t0_c[2*W-1:W];
        end
      end
    end else begin
      for (int i = 2; i < N; i++) begin
        t0_c = csa3(s_c, c_c, in_i[i*W +: W]);
        s_c  = t0_c[W-1:0];
        c_c  = t0_c[2*W-1:W];
      end
    end
  end

  assign sum_o   = s_c;
  assign carry_o = c_c;

endmodule

// File: rtl/ob_lm_table_cnt_seq.sv
// Multi-beat table-count sequencer: walks a wrapping range of table
// entries N per beat, accumulates them in carry-save form, resolves with
// one carry-propagate add and returns the sum over a valid/ready channel.
// Build option OB_LM_TABLE_CNT_SEQ_SAT_EN: saturate rsp_sum on overflow.
module ob_lm_table_cnt_seq
  import ob_pkg::*;
#(
  parameter int         W         = 32,
  parameter int         N         = 4,
  parameter int         ENTRIES_N = 64,
  parameter ob_csa_op_e OP        = CSA_3_2
) (
  input  logic                         clk,
  input  logic                         arst_n,
  input  logic                         cmd_vld,
  output logic                         cmd_rdy,
  input  logic [$clog2(ENTRIES_N)-1:0] cmd_base,
  input  logic [$clog2(ENTRIES_N):0]   cmd_len,
  output logic                         rd_en,
  output logic [$clog2(ENTRIES_N)-1:0] rd_idx,
  input  logic [N*W-1:0]               rd_data,
  output logic                         rsp_vld,
  input  logic                         rsp_rdy,
  output logic [W-1:0]                 rsp_sum,
  output logic                         rsp_ovf,
  output logic                         busy
);

  localparam int IW  = $clog2(ENTRIES_N);
  localparam int LW  = IW + 1;
  localparam int NSH = $clog2(N);
  localparam int WA  = ob_lm_table_cnt_acc_w(W, ENTRIES_N);
  localparam int NI  = N + 2;

  ob_lm_table_cnt_seq_state_t state_q, state_d;

  logic [IW-1:0] addr_q;
  logic [LW-1:0] len_q;
  logic [LW-1:0] beats_q;
  logic [LW-1:0] beat_q;
  logic [LW-1:0] rem_q;
  logic          rd_vld_q;
  logic [WA-1:0] s_q, c_q;
  logic [W-1:0]  sum_q;
  logic          ovf_q;

  logic [LW-1:0]    len_c;
  logic [LW-1:0]    beats_c;
  logic [LW-1:0]    issue_rem_c;
  logic             last_beat_c;
  logic             accept_c;
  logic [NI*WA-1:0] csa_in_c;
  logic [WA-1:0]    csa_s_c, csa_c_c;
  logic [WA-1:0]    cpa_sum_c;

  // Command decode: clamp length, beats = ceil(len/N)
  assign len_c       = (cmd_len > LW'(ENTRIES_N)) ? LW'(ENTRIES_N) : cmd_len;
  assign beats_c     = (len_c + LW'(N - 1)) >> NSH;
  assign accept_c    = (state_q == IDLE) && cmd_vld;
  assign issue_rem_c = len_q - (beat_q << NSH);
  assign last_beat_c = (beat_q == beats_q - LW'(1));
  assign rd_idx      = addr_q;

  // State register
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cmd_vld) state_d = (len_c == '0) ? RSP : FETCH;
      FETCH:   if (last_beat_c) state_d = DRAIN;
      DRAIN:   state_d = CPA;
      CPA:     state_d = RSP;
      RSP:     if (rsp_rdy) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State-decoded outputs
  always_comb begin
    cmd_rdy = 1'b0;
    rd_en   = 1'b0;
    rsp_vld = 1'b0;
    busy    = 1'b1;
    case (state_q)
      IDLE: begin
        cmd_rdy = 1'b1;
        busy    = 1'b0;
      end
      FETCH:   rd_en   = 1'b1;
      RSP:     rsp_vld = 1'b1;
      default: ;
    endcase
  end

  // Command latch, beat counter, address walk and read-return tracking
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      addr_q   <= '0;
      len_q    <= '0;
      beats_q  <= '0;
      beat_q   <= '0;
      rem_q    <= '0;
      rd_vld_q <= 1'b0;
    end else begin
      rd_vld_q <= rd_en;
      rem_q    <= issue_rem_c;
      if (accept_c) begin
        addr_q  <= cmd_base;
        len_q   <= len_c;
        beats_q <= beats_c;
        beat_q  <= '0;
      end else if (state_q == FETCH) begin
        addr_q <= addr_q + IW'(N);
        beat_q <= beat_q + LW'(1);
      end
    end
  end

  // Lane mask: lanes past the remaining count contribute zero
  always_comb begin
    csa_in_c = '0;
    for (int k = 0; k < N; k++) begin
      if (LW'(k) < rem_q) csa_in_c[k*WA +: WA] = WA'(rd_data[k*W +: W]);
    end
    csa_in_c[N*WA +: WA]     = s_q;
    csa_in_c[(N+1)*WA +: WA] = c_q;
  end

  ob_lm_table_cnt_csa #(
    .W  (WA),
    .N  (NI),
    .OP (OP)
  ) u_csa (
    .in_i    (csa_in_c),
    .sum_o   (csa_s_c),
    .carry_o (csa_c_c)
  );

  // Carry-save accumulator: cleared on accept, folds each returning beat
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      s_q <= '0;
      c_q <= '0;
    end else if (accept_c) begin
      s_q <= '0;
      c_q <= '0;
    end else if (rd_vld_q) begin
      s_q <= csa_s_c;
      c_q <= csa_c_c;
    end
  end

  assign cpa_sum_c = s_q + c_q;

  // Result registers: resolved in CPA, zeroed for empty commands
  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      sum_q <= '0;
      ovf_q <= 1'b0;
    end else if (accept_c && (len_c == '0)) begin
      sum_q <= '0;
      ovf_q <= 1'b0;
    end else if (state_q == CPA) begin
      sum_q <= cpa_sum_c[W-1:0];
      ovf_q <= |cpa_sum_c[WA-1:W];
    end
  end

  assign rsp_ovf = ovf_q;
`ifdef OB_LM_TABLE_CNT_SEQ_SAT_EN
  assign rsp_sum = ovf_q ? {W{1'b1}} : sum_q;
`else
  assign rsp_sum = sum_q;
`endif

endmodule

// File: tb/tb_ob_lm_table_cnt_seq.sv
// Self-checking bench for ob_lm_table_cnt_seq (W=32, N=4, ENTRIES_N=64).
module tb_ob_lm_table_cnt_seq;

  logic         clk;
  logic         arst_n;
  logic         cmd_vld;
  logic         cmd_rdy;
  logic [5:0]   cmd_base;
  logic [6:0]   cmd_len;
  logic         rd_en;
  logic [5:0]   rd_idx;
  logic [127:0] rd_data;
  logic         rsp_vld;
  logic         rsp_rdy;
  logic [31:0]  rsp_sum;
  logic         rsp_ovf;
  logic         busy;

  logic [31:0] mem [64];
  int          rd_log[$];
  int          checks   = 0;
  int          failures = 0;

  ob_lm_table_cnt_seq #(.W(32), .N(4), .ENTRIES_N(64)) dut (
    .clk      (clk),
    .arst_n   (arst_n),
    .cmd_vld  (cmd_vld),
    .cmd_rdy  (cmd_rdy),
    .cmd_base (cmd_base),
    .cmd_len  (cmd_len),
    .rd_en    (rd_en),
    .rd_idx   (rd_idx),
    .rd_data  (rd_data),
    .rsp_vld  (rsp_vld),
    .rsp_rdy  (rsp_rdy),
    .rsp_sum  (rsp_sum),
    .rsp_ovf  (rsp_ovf),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Table RAM model: one-cycle read latency, garbage when not reading
  always @(posedge clk) begin
    if (rd_en) begin
      rd_log.push_back(int'(rd_idx));
      for (int k = 0; k < 4; k++) rd_data[k*32 +: 32] <= mem[(int'(rd_idx) + k) % 64];
    end else begin
      rd_data <= {$urandom, $urandom, $urandom, $urandom};
    end
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation did not finish");
  end

  // Reference model: plain sum of the addressed entries
  function automatic int clamp_len(input int len);
    return (len > 64) ? 64 : len;
  endfunction

  function automatic longint unsigned model_sum(input int base, input int len);
    longint unsigned s = 0;
    for (int i = 0; i < clamp_len(len); i++) s += longint'(mem[(base + i) % 64]);
    return s;
  endfunction

  function automatic int model_lat(input int len);
    int lc = clamp_len(len);
    return (lc == 0) ? 1 : (lc + 3) / 4 + 3;
  endfunction

  function automatic logic model_ovf(input longint unsigned s);
    return s >= 64'h1_0000_0000;
  endfunction

  function automatic logic [31:0] model_rsp(input longint unsigned s);
`ifdef OB_LM_TABLE_CNT_SEQ_SAT_EN
    return model_ovf(s) ? 32'hFFFF_FFFF : s[31:0];
`else
    return s[31:0];
`endif
  endfunction

  // Read-index errors against the expected beat walk
  function automatic int read_errs(input int base, input int len);
    int nb = (clamp_len(len) + 3) / 4;
    int e  = (rd_log.size() != nb) ? 1 : 0;
    for (int b = 0; b < rd_log.size() && b < nb; b++)
      if (rd_log[b] != (base + b * 4) % 64) e++;
    return e;
  endfunction

  // Issue one command, wait for the response (bounded), then handshake it
  task automatic run_cmd(input int base, input int len, output int lat,
                         output logic [31:0] sum, output logic ovf);
    @(negedge clk);
    rd_log.delete();
    cmd_base = 6'(base);
    cmd_len  = 7'(len);
    cmd_vld  = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_vld = 1'b0;
    lat = 1;
    while (!rsp_vld && lat < 300) begin
      @(negedge clk);
      lat++;
    end
    sum = rsp_sum;
    ovf = rsp_ovf;
    rsp_rdy = 1'b1;
    @(posedge clk);
    #1 rsp_rdy = 1'b0;
  endtask

  task automatic test_reset();
    checks++; if (cmd_rdy !== 1'b1) begin failures++; $display("FAIL reset_cmd_rdy got=%b exp=1", cmd_rdy); end
    checks++; if (rd_en !== 1'b0) begin failures++; $display("FAIL reset_rd_en got=%b exp=0", rd_en); end
    checks++; if (rsp_vld !== 1'b0) begin failures++; $display("FAIL reset_rsp_vld got=%b exp=0", rsp_vld); end
    checks++; if (rsp_sum !== 32'h0) begin failures++; $display("FAIL reset_rsp_sum got=%h exp=0", rsp_sum); end
    checks++; if (rsp_ovf !== 1'b0) begin failures++; $display("FAIL reset_rsp_ovf got=%b exp=0", rsp_ovf); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
  endtask

  task automatic test_directed();
    int lat; logic [31:0] sum; logic ovf; int e;
    // contiguous range 1..8
    for (int i = 0; i < 64; i++) mem[i] = 32'd0;
    for (int i = 0; i < 8; i++) mem[i] = 32'(i + 1);
    run_cmd(0, 8, lat, sum, ovf);
    checks++; if (lat !== 5) begin failures++; $display("FAIL dir8_latency got=%0d exp=5", lat); end
    checks++; if (sum !== 32'd36) begin failures++; $display("FAIL dir8_sum got=%0d exp=36", sum); end
    checks++; if (ovf !== 1'b0) begin failures++; $display("FAIL dir8_ovf got=%b exp=0", ovf); end
    e = read_errs(0, 8);
    checks++; if (e != 0) begin failures++; $display("FAIL dir8_reads errors=%0d exp=0 nreads=%0d", e, rd_log.size()); end
    // wrapping range with masked tail lanes
    mem[62] = 32'd10; mem[63] = 32'd20; mem[0] = 32'd30; mem[1] = 32'd40; mem[2] = 32'd50;
    mem[3] = 32'd999; mem[4] = 32'd999; mem[5] = 32'd999;
    run_cmd(62, 5, lat, sum, ovf);
    checks++; if (sum !== 32'd150) begin failures++; $display("FAIL wrap_sum got=%0d exp=150", sum); end
    checks++; if (lat !== 5) begin failures++; $display("FAIL wrap_latency got=%0d exp=5", lat); end
    e = read_errs(62, 5);
    checks++; if (e != 0) begin failures++; $display("FAIL wrap_reads errors=%0d exp=0 nreads=%0d", e, rd_log.size()); end
    // empty command
    run_cmd(7, 0, lat, sum, ovf);
    checks++; if (lat !== 1) begin failures++; $display("FAIL len0_latency got=%0d exp=1", lat); end
    checks++; if (sum !== 32'd0) begin failures++; $display("FAIL len0_sum got=%0d exp=0", sum); end
    checks++; if (rd_log.size() != 0) begin failures++; $display("FAIL len0_reads got=%0d exp=0", rd_log.size()); end
    // overflow
    for (int i = 0; i < 4; i++) mem[i] = 32'hFFFF_FFFF;
    run_cmd(0, 4, lat, sum, ovf);
    checks++; if (ovf !== 1'b1) begin failures++; $display("FAIL ovf_flag got=%b exp=1", ovf); end
    checks++; if (sum !== model_rsp(64'h3_FFFF_FFFC)) begin failures++; $display("FAIL ovf_sum got=%h exp=%h", sum, model_rsp(64'h3_FFFF_FFFC)); end
  endtask

  task automatic test_random();
    int lat; logic [31:0] sum; logic ovf; int base; int len; int e;
    longint unsigned ref_s;
    for (int it = 0; it < 30; it++) begin
      for (int i = 0; i < 64; i++)
        mem[i] = (it % 2 == 0) ? $urandom_range(0, 100000) : $urandom;
      base  = $urandom_range(0, 63);
      len   = $urandom_range(0, 80);
      ref_s = model_sum(base, len);
      run_cmd(base, len, lat, sum, ovf);
      checks++; if (lat != model_lat(len)) begin failures++; $display("FAIL rnd_latency it=%0d len=%0d got=%0d exp=%0d", it, len, lat, model_lat(len)); end
      checks++; if (sum !== model_rsp(ref_s)) begin failures++; $display("FAIL rnd_sum it=%0d base=%0d len=%0d got=%h exp=%h", it, base, len, sum, model_rsp(ref_s)); end
      checks++; if (ovf !== model_ovf(ref_s)) begin failures++; $display("FAIL rnd_ovf it=%0d got=%b exp=%b", it, ovf, model_ovf(ref_s)); end
      e = read_errs(base, len);
      checks++; if (e != 0) begin failures++; $display("FAIL rnd_reads it=%0d errors=%0d exp=0", it, e); end
    end
  endtask

  task automatic test_back_to_back();
    int lat; logic [31:0] exp1; logic [31:0] exp2;
    for (int i = 0; i < 64; i++) mem[i] = $urandom_range(0, 5000);
    exp1 = model_rsp(model_sum(5, 4));
    exp2 = model_rsp(model_sum(10, 8));
    @(negedge clk);
    cmd_base = 6'd5; cmd_len = 7'd4; cmd_vld = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_vld = 1'b0;
    lat = 1;
    while (!rsp_vld && lat < 300) begin @(negedge clk); lat++; end
    checks++; if (lat !== 4) begin failures++; $display("FAIL bp_first_latency got=%0d exp=4", lat); end
    // second command pending while the response is held off
    cmd_base = 6'd10; cmd_len = 7'd8; cmd_vld = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      checks++; if (rsp_vld !== 1'b1 || rsp_sum !== exp1) begin failures++; $display("FAIL bp_hold c=%0d vld=%b sum=%h exp_sum=%h", c, rsp_vld, rsp_sum, exp1); end
      checks++; if (cmd_rdy !== 1'b0 || rd_en !== 1'b0) begin failures++; $display("FAIL bp_stall c=%0d cmd_rdy=%b rd_en=%b exp=0,0", c, cmd_rdy, rd_en); end
    end
    rsp_rdy = 1'b1;
    @(posedge clk);
    #1 rsp_rdy = 1'b0;
    @(negedge clk);
    checks++; if (cmd_rdy !== 1'b1) begin failures++; $display("FAIL bp_after_hs cmd_rdy=%b exp=1", cmd_rdy); end
    rd_log.delete();
    @(posedge clk);
    @(negedge clk);
    cmd_vld = 1'b0;
    lat = 1;
    while (!rsp_vld && lat < 300) begin @(negedge clk); lat++; end
    checks++; if (lat !== 5) begin failures++; $display("FAIL bp_second_latency got=%0d exp=5", lat); end
    checks++; if (rsp_sum !== exp2) begin failures++; $display("FAIL bp_second_sum got=%h exp=%h", rsp_sum, exp2); end
    rsp_rdy = 1'b1;
    @(posedge clk);
    #1 rsp_rdy = 1'b0;
  endtask

  task automatic test_reset_mid();
    int lat; logic [31:0] sum; logic ovf;
    for (int i = 0; i < 64; i++) mem[i] = 32'd7;
    @(negedge clk);
    cmd_base = 6'd0; cmd_len = 7'd32; cmd_vld = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cmd_vld = 1'b0;
    repeat (2) @(negedge clk);
    checks++; if (rd_en !== 1'b1) begin failures++; $display("FAIL mid_fetch rd_en=%b exp=1", rd_en); end
    arst_n = 1'b0;
    #1;
    checks++; if (rd_en !== 1'b0 || busy !== 1'b0 || cmd_rdy !== 1'b1) begin failures++; $display("FAIL mid_abort rd_en=%b busy=%b cmd_rdy=%b exp=0,0,1", rd_en, busy, cmd_rdy); end
    @(negedge clk);
    arst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (rd_en !== 1'b0 || rsp_vld !== 1'b0) begin failures++; $display("FAIL mid_quiet rd_en=%b rsp_vld=%b exp=0,0", rd_en, rsp_vld); end
    for (int i = 0; i < 4; i++) mem[i] = 32'd1;
    run_cmd(0, 4, lat, sum, ovf);
    checks++; if (sum !== 32'd4) begin failures++; $display("FAIL mid_next_sum got=%0d exp=4", sum); end
    checks++; if (lat !== 4) begin failures++; $display("FAIL mid_next_latency got=%0d exp=4", lat); end
  endtask

  initial begin
    arst_n   = 1'b0;
    cmd_vld  = 1'b0;
    cmd_base = '0;
    cmd_len  = '0;
    rsp_rdy  = 1'b0;
    for (int i = 0; i < 64; i++) mem[i] = 32'd0;
    repeat (3) @(negedge clk);
    test_reset();
    arst_n = 1'b1;
    repeat (2) @(negedge clk);
    test_reset();
    test_directed();
    test_random();
    test_back_to_back();
    test_reset_mid();
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
